// File: rtl/nx_stream_multicaster_pkg.sv
// Shared message definitions for the node fabric.
// The multicaster and its egress FIFOs import their payload type from here.
package NXConstants;

    localparam int MESSAGE_WIDTH = 8;

    typedef logic [MESSAGE_WIDTH-1:0] node_message_t;

endpackage : NXConstants

// File: rtl/nx_fifo.sv
// Synchronous FIFO with registered storage and head-of-queue read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module nx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Read/write pointers; reset discards every buffered entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Payload storage, written at the tail slot.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_rst) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule : nx_fifo

// File: rtl/nx_stream_multicaster.sv
// Fans one inbound message stream out to STREAMS egress FIFOs by mask.
// Delivery is all-or-nothing; zero-mask accepts are counted as drops.
module nx_stream_multicaster
    import NXConstants::*;
#(
    parameter int STREAMS    = 4,
    parameter int DEPTH      = 2,
    parameter int DROP_WIDTH = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    output logic                             o_idle,
    input  logic [STREAMS-1:0]               i_inbound_mask,
    input  node_message_t                    i_inbound_data,
    input  logic                             i_inbound_valid,
    output logic                             o_inbound_ready,
    output logic [STREAMS*MESSAGE_WIDTH-1:0] o_outbound_data,
    output logic [STREAMS-1:0]               o_outbound_valid,
    input  logic [STREAMS-1:0]               i_outbound_ready,
    output logic [DROP_WIDTH-1:0]            o_dropped
);

    localparam logic [DROP_WIDTH-1:0] DROP_ONE = {{(DROP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

    logic [STREAMS-1:0]    w_full;
    logic [STREAMS-1:0]    w_empty;
    logic [STREAMS-1:0]    w_push;
    logic [STREAMS-1:0]    w_pop;
    logic                  w_accept;
    logic                  w_drop;
    logic [DROP_WIDTH-1:0] r_dropped;

    // Ready only looks at targeted streams so unrelated back-pressure never blocks.
    assign o_inbound_ready  = ((i_inbound_mask & w_full) == {STREAMS{1'b0}});
    assign w_accept         = i_inbound_valid & o_inbound_ready & ~i_rst;
    assign w_push           = i_inbound_mask & {STREAMS{w_accept}};
    assign w_drop           = w_accept & (i_inbound_mask == {STREAMS{1'b0}});
    assign o_outbound_valid = ~w_empty & {STREAMS{~i_rst}};
    assign w_pop            = o_outbound_valid & i_outbound_ready;
    assign o_idle           = ((&w_empty) | i_rst) & ~i_inbound_valid;
    assign o_dropped        = i_rst ? {DROP_WIDTH{1'b0}} : r_dropped;

    // Saturating count of accepted messages that had no target.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dropped <= {DROP_WIDTH{1'b0}};
        end else if (w_drop && (r_dropped != DROP_MAX)) begin
            r_dropped <= r_dropped + DROP_ONE;
        end else begin
            r_dropped <= r_dropped;
        end
    end

    for (genvar s = 0; s < STREAMS; s++) begin : g_stream
        nx_fifo #(
            .WIDTH ($bits(node_message_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (w_push[s]),
            .i_data  (i_inbound_data),
            .i_pop   (w_pop[s]),
            .o_data  (o_outbound_data[s*MESSAGE_WIDTH +: MESSAGE_WIDTH]),
            .o_empty (w_empty[s]),
            .o_full  (w_full[s])
        );
    end

endmodule : nx_stream_multicaster

// File: tb/tb_nx_stream_multicaster.sv
// Scoreboard bench for nx_stream_multicaster: per-stream expected queues
// filled on accept and drained on pop, plus directed scenario checks.
module tb_nx_stream_multicaster;
    import NXConstants::*;

    localparam int STREAMS = 4;
    localparam int DEPTH   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    mask = 4'h0;
    node_message_t data = 8'h00;
    logic          in_valid = 1'b0;
    logic [3:0]    out_ready = 4'hF;

    logic          o_idle, o_ready;
    logic [31:0]   o_data;
    logic [3:0]    o_valid;
    logic [15:0]   o_dropped;

    logic          sat_idle, sat_ready;
    logic [31:0]   sat_data;
    logic [3:0]    sat_valid;
    logic [1:0]    sat_dropped;

    int vectors = 0;
    int miscompares = 0;
    int pops3 = 0;
    node_message_t exp_q [STREAMS][$];

    nx_stream_multicaster #(.STREAMS(4), .DEPTH(2), .DROP_WIDTH(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .o_idle(o_idle),
        .i_inbound_mask(mask), .i_inbound_data(data), .i_inbound_valid(in_valid),
        .o_inbound_ready(o_ready), .o_outbound_data(o_data),
        .o_outbound_valid(o_valid), .i_outbound_ready(out_ready), .o_dropped(o_dropped)
    );

    nx_stream_multicaster #(.STREAMS(4), .DEPTH(2), .DROP_WIDTH(2)) u_dut_sat (
        .i_clk(clk), .i_rst(rst), .o_idle(sat_idle),
        .i_inbound_mask(mask), .i_inbound_data(data), .i_inbound_valid(in_valid),
        .o_inbound_ready(sat_ready), .o_outbound_data(sat_data),
        .o_outbound_valid(sat_valid), .i_outbound_ready(out_ready), .o_dropped(sat_dropped)
    );

    always #5 clk = ~clk;

    // Scoreboard: expected ready/valid from queue occupancy, pops compared, accepts pushed.
    always @(negedge clk) begin
        logic [3:0] exp_valid;
        logic       exp_ready;
        if (rst) begin
            for (int s = 0; s < STREAMS; s++) exp_q[s].delete();
        end else begin
            exp_ready = 1'b1;
            for (int s = 0; s < STREAMS; s++) begin
                exp_valid[s] = (exp_q[s].size() != 0);
                if (mask[s] && exp_q[s].size() == DEPTH) exp_ready = 1'b0;
            end
            vectors++;
            if (o_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL sb_ready: got %b expected %b at %0t", o_ready, exp_ready, $time);
            end
            vectors++;
            if (o_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL sb_valid: got %b expected %b at %0t", o_valid, exp_valid, $time);
            end
            vectors++;
            if ({sat_valid, sat_ready, sat_data, sat_idle} !== {o_valid, o_ready, o_data, o_idle}) begin
                miscompares++;
                $display("FAIL sat_mirror: got %h expected %h at %0t",
                         {sat_valid, sat_ready, sat_data, sat_idle}, {o_valid, o_ready, o_data, o_idle}, $time);
            end
            for (int s = 0; s < STREAMS; s++) begin
                if (exp_valid[s] && out_ready[s]) begin
                    vectors++;
                    if (o_data[s*8 +: 8] !== exp_q[s][0]) begin
                        miscompares++;
                        $display("FAIL sb_data[%0d]: got %h expected %h at %0t",
                                 s, o_data[s*8 +: 8], exp_q[s][0], $time);
                    end
                    void'(exp_q[s].pop_front());
                    if (s == 3) pops3++;
                end
            end
            if (in_valid && exp_ready) begin
                for (int s = 0; s < STREAMS; s++) begin
                    if (mask[s]) exp_q[s].push_back(data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] m, input node_message_t d);
        mask = m;
        data = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        vectors++;
        if ({o_valid, o_dropped, o_idle, sat_dropped} !== {4'h0, 16'h0, 1'b1, 2'h0}) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b dropped=%0d idle=%b sat=%0d expected 0000/0/1/0",
                     o_valid, o_dropped, o_idle, sat_dropped);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_zero_mask();
        out_ready = 4'hF;
        for (int i = 0; i < 3; i++) send(4'h0, node_message_t'(i));
        @(negedge clk);
        vectors++;
        if ({o_dropped, sat_dropped, o_valid} !== {16'd3, 2'd3, 4'h0}) begin
            miscompares++;
            $display("FAIL drop3: got dropped=%0d sat=%0d valid=%b expected 3/3/0000",
                     o_dropped, sat_dropped, o_valid);
        end
        step();
        for (int i = 0; i < 2; i++) send(4'h0, node_message_t'(i));
        @(negedge clk);
        vectors++;
        if ({o_dropped, sat_dropped} !== {16'd5, 2'd3}) begin
            miscompares++;
            $display("FAIL drop_sat: got dropped=%0d sat=%0d expected 5/3", o_dropped, sat_dropped);
        end
        step();
    endtask

    task automatic test_broadcast();
        out_ready = 4'hF;
        send(4'hF, 8'hA5);
        @(negedge clk);
        vectors++;
        if ({o_valid, o_dropped} !== {4'hF, 16'd5}) begin
            miscompares++;
            $display("FAIL bcast_valid: got valid=%b dropped=%0d expected 1111/5", o_valid, o_dropped);
        end
        for (int s = 0; s < STREAMS; s++) begin
            vectors++;
            if (o_data[s*8 +: 8] !== 8'hA5) begin
                miscompares++;
                $display("FAIL bcast_data[%0d]: got %h expected a5", s, o_data[s*8 +: 8]);
            end
        end
        repeat (2) step();
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1011;
        send(4'b0100, 8'h01);
        send(4'b0100, 8'h02);
        mask = 4'b0101;
        data = 8'h03;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({o_ready, o_valid[0]} !== 2'b00) begin
                miscompares++;
                $display("FAIL bp_block: got ready=%b valid0=%b expected 0/0", o_ready, o_valid[0]);
            end
            step();
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_popcycle: got ready=%b expected 0", o_ready);
        end
        step();
        out_ready[2] = 1'b0;
        @(negedge clk);
        vectors++;
        if ({o_ready, o_valid[0]} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_release: got ready=%b valid0=%b expected 1/0", o_ready, o_valid[0]);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_valid[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_deliver: got valid0=%b expected 1", o_valid[0]);
        end
        step();
        out_ready = 4'hF;
        repeat (4) step();
    endtask

    task automatic test_full_pop();
        out_ready = 4'b1101;
        send(4'b0010, 8'h10);
        send(4'b0010, 8'h11);
        mask = 4'b0010;
        data = 8'h12;
        in_valid = 1'b1;
        out_ready = 4'hF;
        @(negedge clk);
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_same: got ready=%b expected 0", o_ready);
        end
        step();
        @(negedge clk);
        vectors++;
        if (o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fullpop_next: got ready=%b expected 1", o_ready);
        end
        step();
        in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        vectors++;
        if (exp_q[1].size() != 0 || o_valid[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_drain: got left=%0d valid1=%b expected 0/0", exp_q[1].size(), o_valid[1]);
        end
        step();
    endtask

    task automatic test_order_wrap();
        int sent = 0;
        int cycles = 0;
        logic acc;
        pops3 = 0;
        out_ready = 4'hF;
        mask = 4'b1000;
        in_valid = 1'b1;
        while (sent < 10 && cycles < 200) begin
            data = node_message_t'(sent);
            out_ready[3] = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = o_ready;
            step();
            if (acc) sent++;
            cycles++;
        end
        in_valid = 1'b0;
        vectors++;
        if (sent != 10) begin
            miscompares++;
            $display("FAIL order_send_timeout: got %0d sent expected 10", sent);
        end
        while (exp_q[3].size() != 0 && cycles < 400) begin
            out_ready[3] = 1'($urandom_range(0, 1));
            step();
            cycles++;
        end
        out_ready = 4'hF;
        repeat (2) step();
        @(negedge clk);
        vectors++;
        if (pops3 != 10 || o_valid[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL order_count: got pops=%0d valid3=%b expected 10/0", pops3, o_valid[3]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 4'h0;
        send(4'hF, 8'h20);
        send(4'hF, 8'h21);
        @(negedge clk);
        vectors++;
        if (o_valid !== 4'hF) begin
            miscompares++;
            $display("FAIL rstmid_fill: got valid=%b expected 1111", o_valid);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({o_valid, o_dropped, o_idle} !== {4'h0, 16'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_clear: got valid=%b dropped=%0d idle=%b expected 0000/0/1",
                     o_valid, o_dropped, o_idle);
        end
        step();
        out_ready = 4'hF;
        send(4'hF, 8'h30);
        @(negedge clk);
        vectors++;
        if (o_valid !== 4'hF) begin
            miscompares++;
            $display("FAIL rstmid_accept: got valid=%b expected 1111", o_valid);
        end
        repeat (2) step();
        @(negedge clk);
        vectors++;
        if (o_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL final_idle: got %b expected 1", o_idle);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_zero_mask();
        test_broadcast();
        test_backpressure();
        test_full_pop();
        test_order_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_nx_stream_multicaster

// File: doc/nx_stream_multicaster.md
NX_STREAM_MULTICASTER -- requirements
Module: nx_stream_multicaster

Interface
REQ-001 SHALL take parameter STREAMS, default 4: number of outbound streams, legal range 2..16.
REQ-002 SHALL take parameter DEPTH, default 2: per-stream egress FIFO depth in entries, power of two, at least 2.
REQ-003 SHALL take parameter DROP_WIDTH, default 16: width of the drop counter.
REQ-004 i_clk  input  1  single clock; all logic rises on i_clk.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 o_idle  output  1  block holds no messages and no inbound message is offered.
REQ-007 i_inbound_mask  input  STREAMS  one bit per target stream; any subset is legal.
REQ-008 i_inbound_data  input  node_message_t  message payload.
REQ-009 i_inbound_valid  input  1  inbound message present.
REQ-010 o_inbound_ready  output  1  inbound accept.
REQ-011 o_outbound_data  output  STREAMS x MESSAGE_WIDTH  per-stream head-of-FIFO data.
REQ-012 o_outbound_valid  output  STREAMS  per-stream valid.
REQ-013 i_outbound_ready  input  STREAMS  per-stream ready.
REQ-014 o_dropped  output  DROP_WIDTH  count of accepted messages that had a zero mask.

Function
REQ-015 SHALL drive o_inbound_ready high exactly when (i_inbound_mask AND fifo_full) equals zero; it SHALL NOT depend on i_inbound_valid.
REQ-016 SHALL treat a message as accepted on a cycle where i_inbound_valid and o_inbound_ready are both high.
REQ-017 On accept, SHALL push the same data into every FIFO whose mask bit is set, in that one cycle: all-or-nothing, never a partial delivery.
REQ-018 SHALL treat an accepted message with a zero mask as a drop: no FIFO is written, and o_dropped increments by 1, saturating at all-ones.
REQ-019 SHALL NOT push into any FIFO while i_inbound_valid is low, whatever the mask value.
REQ-020 Latency: data accepted at edge N SHALL be visible on o_outbound_valid/o_outbound_data of each targeted stream from edge N (one cycle, no combinational bypass).
REQ-021 SHALL drive o_outbound_valid[s] as NOT fifo_empty[s], and SHALL pop stream s when o_outbound_valid[s] and i_outbound_ready[s] are both high.
REQ-022 SHALL keep each stream independent: back-pressure on stream s affects only messages whose mask includes s.
REQ-023 Full FIFO with a pop in the same cycle: SHALL still report not-ready for masks including that stream; there is no same-cycle pass-through.
REQ-024 SHALL preserve message order per stream; FIFO pointer wrap at DEPTH SHALL be transparent to the consumer.
REQ-025 SHALL hold o_outbound_data stable while o_outbound_valid is high and not popped.
REQ-026 SHALL drive o_idle as (all FIFOs empty) AND NOT i_inbound_valid.

Reset
REQ-027 While i_rst is high: all FIFOs empty, o_outbound_valid all zero, o_dropped zero, o_idle equal to NOT i_inbound_valid; no push or pop takes effect.
REQ-028 Reset asserted mid-operation SHALL discard all buffered messages within the same edge; the first accept is possible on the cycle after i_rst falls.

Structure
REQ-029 node_message_t and MESSAGE_WIDTH SHALL come from NXConstants; no new package types are required.
REQ-030 SHALL instantiate the existing nx_fifo, once per stream, with DEPTH entries and width $bits(node_message_t); the drop counter and ready/push logic SHALL be local.

Verification
REQ-031 Broadcast: mask 4'b1111, data 0xA5, all readies high -> all four valids high the next cycle carrying 0xA5; o_dropped stays 0.
REQ-032 Multicast under back-pressure: DEPTH=2, i_outbound_ready[2]=0, two messages with mask 4'b0100 fill stream 2; a third with mask 4'b0101 -> o_inbound_ready=0 and stream 0 receives nothing until stream 2 pops once.
REQ-033 Zero mask: 3 valid messages with mask 0 -> o_dropped=3 and no outbound valid. With DROP_WIDTH=2, 5 such messages -> o_dropped holds at 3.
REQ-034 Full plus simultaneous pop: stream 1 full, i_outbound_ready[1]=1, mask 4'b0010 offered -> ready low that cycle, high the next, and the message is accepted.
REQ-035 Order and wrap: 10 messages 0..9 to stream 3 with random ready -> stream 3 emits 0..9 in order, none lost or duplicated.
REQ-036 Reset mid-stream: i_rst pulsed with 2 entries buffered in each FIFO -> all valids low and o_dropped 0 the next cycle; o_idle high.
